// File: rtl/sdram_init_refresh.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_refresh
// Desc     : SDRAM power-up sequencer (wait, PRECHARGE ALL, N x AUTO REFRESH,
//            LOAD MODE) followed by an owed-refresh scheduler for the
//            controller. Macro REFRESH_STATS_EN builds the REF_COUNT counter.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init_refresh #(
  parameter int         INIT_WAIT_CYCLES = 10000,
  parameter int         T_RP             = 2,
  parameter int         T_RFC            = 7,
  parameter int         T_MRD            = 2,
  parameter int         INIT_REFRESHES   = 8,
  parameter int         REFI_CYCLES      = 390,
  parameter int         MAX_OWED         = 8,
  parameter int         CAS_LATENCY      = 2,
  parameter logic [2:0] BURST_CODE       = 3'b010
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REF_ACK,
  output logic        INIT_DONE,
  output logic        RAS,
  output logic        CAS,
  output logic        WE,
  output logic [12:0] MA,
  output logic [1:0]  BA,
  output logic        REF_REQ,
  output logic        REF_URGENT,
  output logic [3:0]  OWED,
  output logic        OVERRUN,
  output logic [15:0] REF_COUNT
);

  typedef enum logic [2:0] {
    S_WAIT     = 3'd0,
    S_PRE      = 3'd1,
    S_PRE_WAIT = 3'd2,
    S_REF      = 3'd3,
    S_REF_WAIT = 3'd4,
    S_MRS      = 3'd5,
    S_MRS_WAIT = 3'd6,
    S_RUN      = 3'd7
  } state_t;

  localparam logic [2:0]  CMD_NOP = 3'b111;
  localparam logic [2:0]  CMD_PRE = 3'b010;
  localparam logic [2:0]  CMD_REF = 3'b001;
  localparam logic [2:0]  CMD_MRS = 3'b000;

  localparam logic [15:0] C_INIT_WAIT = 16'(INIT_WAIT_CYCLES);
  localparam logic [15:0] C_T_RP_M1   = 16'(T_RP - 1);
  localparam logic [15:0] C_T_RFC_M1  = 16'(T_RFC - 1);
  localparam logic [15:0] C_T_MRD_M1  = 16'(T_MRD - 1);
  localparam logic [7:0]  C_REFS_M1   = 8'(INIT_REFRESHES - 1);
  localparam logic [15:0] C_REFI_M1   = 16'(REFI_CYCLES - 1);
  localparam logic [3:0]  C_MAX       = 4'(MAX_OWED);
  localparam logic [3:0]  C_MAX_M1    = 4'(MAX_OWED - 1);
  localparam logic [2:0]  C_CL        = 3'(CAS_LATENCY);
  localparam logic [12:0] C_MODE_WORD = {3'b000, 1'b0, 2'b00, C_CL, 1'b0, BURST_CODE};

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  ref_cnt_q, ref_cnt_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [12:0] ma_q, ma_d;
  logic [1:0]  ba_q, ba_d;
  logic        done_q, done_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  owed_q, owed_d;
  logic        overrun_q, overrun_d;
  logic        run, tick, ack;

  assign run  = (state_q == S_RUN);
  assign tick = run && (timer_q == 16'd0);
  assign ack  = run && REF_ACK;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_cnt_d = ref_cnt_q;
    case (state_q)
      // The cycle that sees reset release is the first wait cycle, hence the full count.
      S_WAIT: begin
        if (cnt_q == C_INIT_WAIT) begin
          state_d = S_PRE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PRE: state_d = S_PRE_WAIT;
      S_PRE_WAIT: begin
        if (cnt_q == C_T_RP_M1) begin
          state_d = S_REF;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_REF: state_d = S_REF_WAIT;
      S_REF_WAIT: begin
        if (cnt_q == C_T_RFC_M1) begin
          cnt_d = 16'd0;
          if (ref_cnt_q == C_REFS_M1) begin
            state_d   = S_MRS;
            ref_cnt_d = 8'd0;
          end else begin
            state_d   = S_REF;
            ref_cnt_d = ref_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MRS: state_d = S_MRS_WAIT;
      S_MRS_WAIT: begin
        if (cnt_q == C_T_MRD_M1) begin
          state_d = S_RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Pin values are decoded from the next state so they register alongside it.
  always_comb begin
    cmd_d  = CMD_NOP;
    ma_d   = 13'd0;
    ba_d   = 2'd0;
    done_d = 1'b0;
    case (state_d)
      S_PRE: begin
        cmd_d     = CMD_PRE;
        ma_d[10]  = 1'b1;
      end
      S_REF: cmd_d = CMD_REF;
      S_MRS: begin
        cmd_d = CMD_MRS;
        ma_d  = C_MODE_WORD;
      end
      S_RUN:   done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  always_comb begin
    timer_d   = timer_q;
    owed_d    = owed_q;
    overrun_d = overrun_q;
    if (run) begin
      timer_d = tick ? C_REFI_M1 : timer_q - 16'd1;
    end else if (state_d == S_RUN) begin
      timer_d = C_REFI_M1;
    end
    // A tick and an ack in the same cycle cancel out.
    if (tick && !ack) begin
      if (owed_q >= C_MAX) begin
        overrun_d = 1'b1;
      end else begin
        owed_d = owed_q + 4'd1;
      end
    end else if (ack && !tick && owed_q != 4'd0) begin
      owed_d = owed_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_WAIT;
      cnt_q     <= 16'd0;
      ref_cnt_q <= 8'd0;
      cmd_q     <= CMD_NOP;
      ma_q      <= 13'd0;
      ba_q      <= 2'd0;
      done_q    <= 1'b0;
      timer_q   <= 16'd0;
      owed_q    <= 4'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_cnt_d;
      cmd_q     <= cmd_d;
      ma_q      <= ma_d;
      ba_q      <= ba_d;
      done_q    <= done_d;
      timer_q   <= timer_d;
      owed_q    <= owed_d;
      overrun_q <= overrun_d;
    end
  end

  assign {RAS, CAS, WE} = cmd_q;
  assign MA             = ma_q;
  assign BA             = ba_q;
  assign INIT_DONE      = done_q;
  assign OWED           = owed_q;
  assign OVERRUN        = overrun_q;
  assign REF_REQ        = (owed_q != 4'd0);
  assign REF_URGENT     = (owed_q >= C_MAX_M1);

`ifdef REFRESH_STATS_EN
  logic [15:0] ref_count_q, ref_count_d;

  always_comb begin
    ref_count_d = ref_count_q;
    if (ack && (owed_q != 4'd0 || tick) && ref_count_q != 16'hFFFF) begin
      ref_count_d = ref_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ref_count_q <= 16'd0;
    end else begin
      ref_count_q <= ref_count_d;
    end
  end

  assign REF_COUNT = ref_count_q;
`else
  assign REF_COUNT = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_refresh.sv
`default_nettype none
// Bench for sdram_init_refresh: scoreboard of per-cycle expected pin values built from
// the documented init timeline plus a small owed-refresh model.
module tb_sdram_init_refresh;

  localparam int REFI = 10;
  localparam int MAXO = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REF_ACK = 1'b0;
  logic        INIT_DONE, RAS, CAS, WE, REF_REQ, REF_URGENT, OVERRUN;
  logic [12:0] MA;
  logic [1:0]  BA;
  logic [3:0]  OWED;
  logic [15:0] REF_COUNT;

  int checks = 0;
  int failures = 0;
  int cyc = -1;
  int m_owed = 0;
  int m_cnt = 0;
  bit m_over = 1'b0;
  logic [41:0] sb[$];
  logic [41:0] x;

  sdram_init_refresh #(
    .INIT_WAIT_CYCLES(20), .T_RP(2), .T_RFC(7), .T_MRD(2), .INIT_REFRESHES(2),
    .REFI_CYCLES(REFI), .MAX_OWED(MAXO), .CAS_LATENCY(2), .BURST_CODE(3'b010)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REF_ACK(REF_ACK), .INIT_DONE(INIT_DONE),
    .RAS(RAS), .CAS(CAS), .WE(WE), .MA(MA), .BA(BA), .REF_REQ(REF_REQ),
    .REF_URGENT(REF_URGENT), .OWED(OWED), .OVERRUN(OVERRUN), .REF_COUNT(REF_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [41:0] got();
    return {RAS, CAS, WE, MA, BA, INIT_DONE, OWED, REF_REQ, REF_URGENT, OVERRUN, REF_COUNT};
  endfunction

  // Drives one clock edge worth of stimulus and pushes the outputs expected after it.
  task automatic drive_cycle(input logic ack);
    int e;
    bit tick, acc;
    logic [2:0]  c;
    logic [12:0] a;
    logic [15:0] cnt_exp;
    e = cyc + 1;
    REF_ACK = ack;
    tick = (e >= 42 + REFI) && (((e - 42) % REFI) == 0);
    acc  = ack && (e >= 43);
    if (acc && (m_owed > 0 || tick) && m_cnt < 65535) m_cnt++;
    if (tick && !acc) begin
      if (m_owed == MAXO) m_over = 1'b1;
      else m_owed++;
    end else if (acc && !tick && m_owed > 0) begin
      m_owed--;
    end
    c = 3'b111;
    a = 13'h000;
    if (e == 20) begin
      c = 3'b010; a = 13'h400;
    end else if (e == 23 || e == 31) begin
      c = 3'b001;
    end else if (e == 39) begin
      c = 3'b000; a = 13'h022;
    end
`ifdef REFRESH_STATS_EN
    cnt_exp = 16'(m_cnt);
`else
    cnt_exp = 16'h0000;
`endif
    sb.push_back({c, a, 2'b00, (e >= 42), 4'(m_owed), (m_owed != 0), (m_owed >= MAXO - 1),
                  m_over, cnt_exp});
    @(negedge CLK);
    cyc = e;
  endtask

  task automatic apply_reset();
    REF_ACK = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    cyc = -1; m_owed = 0; m_cnt = 0; m_over = 1'b0;
  endtask

  task automatic test_reset();
    REF_ACK = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (got() !== {3'b111, 13'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", got(),
               {3'b111, 13'd0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    end
    RESET = 1'b0;
    cyc = -1; m_owed = 0; m_cnt = 0; m_over = 1'b0;
  endtask

  task automatic test_init_sequence(input string name);
    while (cyc < 44) begin
      drive_cycle(1'b0);
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got(), x);
      end
    end
  endtask

  task automatic test_refresh_accrual();
    while (cyc < 140) begin
      drive_cycle(1'b0);
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        failures++;
        $display("FAIL accrual cyc=%0d got=%h exp=%h", cyc, got(), x);
      end
      if (cyc == 52) begin
        checks++;
        if (OWED !== 4'd1) begin
          failures++; $display("FAIL accrual_first_tick got=%0d exp=1", OWED);
        end
      end
    end
    checks++;
    if ({OWED, REF_URGENT, OVERRUN} !== {4'd8, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL accrual_saturate owed=%0d urg=%b ovr=%b exp 8/1/1", OWED, REF_URGENT, OVERRUN);
    end
  endtask

  task automatic test_ack_drain();
    while (cyc < 151) begin
      drive_cycle(cyc + 1 <= 150);
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        failures++;
        $display("FAIL ack_drain cyc=%0d got=%h exp=%h", cyc, got(), x);
      end
    end
    checks++;
    if ({OWED, REF_REQ, OVERRUN} !== {4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ack_at_zero owed=%0d req=%b ovr=%b exp 0/0/1", OWED, REF_REQ, OVERRUN);
    end
  endtask

  task automatic test_mid_run_reset();
    while (cyc < 195) begin
      drive_cycle(1'b0);
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, got(), x);
      end
    end
    checks++;
    if (OWED !== 4'd5) begin
      failures++; $display("FAIL owed_before_reset got=%0d exp=5", OWED);
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({INIT_DONE, OWED, OVERRUN} !== {1'b0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset done=%b owed=%0d ovr=%b exp 0/0/0", INIT_DONE, OWED, OVERRUN);
    end
    @(negedge CLK);
    RESET = 1'b0;
    cyc = -1; m_owed = 0; m_cnt = 0; m_over = 1'b0;
    test_init_sequence("reinit");
  endtask

  task automatic test_collision();
    while (cyc < 86) begin
      drive_cycle(cyc + 1 >= 82);
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        failures++;
        $display("FAIL collision cyc=%0d got=%h exp=%h", cyc, got(), x);
      end
      if (cyc == 82) begin
        checks++;
        if (OWED !== 4'd3) begin
          failures++; $display("FAIL collision_owed got=%0d exp=3", OWED);
        end
      end
    end
    checks++;
    if ({OWED, REF_REQ} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL collision_underflow owed=%0d req=%b exp 0/0", OWED, REF_REQ);
    end
  endtask

  task automatic test_stats();
    logic [15:0] want;
    apply_reset();
    while (cyc < 85) begin
      drive_cycle((cyc + 1 == 10) || (cyc + 1 == 30) || (cyc + 1 == 42) ||
                  ((cyc + 1 >= 53) && ((cyc + 1 - 53) % 10 == 0)));
      x = sb.pop_front();
      checks++;
      if (got() !== x) begin
        failures++;
        $display("FAIL stats cyc=%0d got=%h exp=%h", cyc, got(), x);
      end
    end
`ifdef REFRESH_STATS_EN
    want = 16'd4;
`else
    want = 16'd0;
`endif
    checks++;
    if ({REF_COUNT, OWED} !== {want, 4'd0}) begin
      failures++;
      $display("FAIL stats_count count=%0d owed=%0d exp %0d/0", REF_COUNT, OWED, want);
    end
  endtask

  initial begin
    test_reset();
    test_init_sequence("init");
    test_refresh_accrual();
    test_ack_drain();
    test_mid_run_reset();
    test_collision();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
